// File: rtl/flop_share_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters' writes into one shared WIDTH-bit register,
// with an optional bounded lock that lets one requester keep ownership for consecutive writes.
module flop_share_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MAXLOCK = 4,
    localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  qvalid,
    output logic [PW-1:0]         owner
);

    localparam int unsigned CW = $clog2(MAXLOCK + 1);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   lockcnt, lockcnt_nxt;
    logic            we;
    logic [PW-1:0]   widx;
    logic            found;
    logic [PW-1:0]   win;
    logic [PW:0]     sidx;
    logic [WIDTH-1:0] wd [NREQ];

    function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] x);
        return (x == PW'(NREQ - 1)) ? '0 : PW'(x + 1'b1);
    endfunction

    // Unpack the write data bus into per-requester words.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wd[i] = wdata[i*WIDTH +: WIDTH];
        end
    end

    // First requesting index at or after ptr, with wrap-around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sidx = {1'b0, ptr} + (PW+1)'(k);
            if (sidx >= (PW+1)'(NREQ)) begin
                sidx = sidx - (PW+1)'(NREQ);
            end
            if (!found && req[sidx[PW-1:0]]) begin
                found = 1'b1;
                win   = sidx[PW-1:0];
            end
        end
    end

    // Next-state, grant and write-enable decode.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        lockcnt_nxt = lockcnt;
        gnt         = '0;
        we          = 1'b0;
        widx        = win;
        if (!reset) begin
            case (state)
                ARB: begin
                    if (found) begin
                        gnt[win] = 1'b1;
                        we       = 1'b1;
                        if (lock[win] && (MAXLOCK > 1)) begin
                            state_nxt   = LOCKED;
                            lockcnt_nxt = CW'(1);
                        end else begin
                            ptr_nxt = inc_wrap(win);
                        end
                    end
                end
                LOCKED: begin
                    // owner always holds the lock holder while LOCKED
                    widx = owner;
                    if (req[owner] && lock[owner]
                        && (CW'(lockcnt + 1'b1) != CW'(MAXLOCK))) begin
                        gnt[owner]  = 1'b1;
                        we          = 1'b1;
                        lockcnt_nxt = CW'(lockcnt + 1'b1);
                    end else begin
                        gnt[owner]  = req[owner];
                        we          = req[owner];
                        state_nxt   = ARB;
                        ptr_nxt     = inc_wrap(owner);
                        lockcnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt   = ARB;
                    lockcnt_nxt = '0;
                end
            endcase
        end
    end

    // Arbiter state and shared register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB;
            ptr     <= '0;
            lockcnt <= '0;
            q       <= '0;
            qvalid  <= 1'b0;
            owner   <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lockcnt <= lockcnt_nxt;
            if (we) begin
                q      <= wd[widx];
                qvalid <= 1'b1;
                owner  <= widx;
            end
        end
    end

endmodule

// File: tb/tb_flop_share_arbiter.sv
// Self-checking bench for flop_share_arbiter: grants checked each cycle, expected register
// contents queued on each grant and compared after the capturing edge.
module tb_flop_share_arbiter;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned MAXLOCK = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       lock = '0;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  qvalid;
    logic [1:0]            owner;

    logic [WIDTH-1:0] tb_wd [NREQ];
    logic [9:0]       sb [$];
    logic [WIDTH-1:0] last_q;
    logic [1:0]       last_owner;
    logic             last_qvalid;
    int               n_checks = 0;
    int               n_errors = 0;

    flop_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAXLOCK(MAXLOCK)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt), .q(q), .qvalid(qvalid), .owner(owner)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = tb_wd[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, check its grant, then check the register after the edge.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                        input logic [3:0] exp_gnt);
        logic [9:0] e;
        @(negedge clk);
        req  = r;
        lock = l;
        #1;
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        for (int i = 0; i < NREQ; i++) begin
            if (exp_gnt[i]) sb.push_back({2'(i), tb_wd[i]});
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e           = sb.pop_front();
            last_q      = e[7:0];
            last_owner  = e[9:8];
            last_qvalid = 1'b1;
        end
        check({tag, "_q"}, 32'(q), 32'(last_q));
        check({tag, "_owner"}, 32'(owner), 32'(last_owner));
        check({tag, "_qvalid"}, 32'(qvalid), 32'(last_qvalid));
    endtask

    task automatic do_reset(input logic [3:0] r, input logic [3:0] l);
        @(negedge clk);
        reset = 1'b1;
        req   = r;
        lock  = l;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        sb.delete();
        last_q      = '0;
        last_owner  = '0;
        last_qvalid = 1'b0;
        check("rst_q", 32'(q), 32'd0);
        check("rst_qvalid", 32'(qvalid), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) tb_wd[i] = 8'h10 + 8'(i);
        repeat (2) @(posedge clk);
        do_reset(4'b0000, 4'b0000);

        // Idle after reset
        for (int i = 0; i < 3; i++) step("idle", 4'b0000, 4'b0000, 4'b0000);

        // Plain rotation across all requesters
        step("rr0", 4'b1111, 4'b0000, 4'b0001);
        step("rr1", 4'b1111, 4'b0000, 4'b0010);
        step("rr2", 4'b1111, 4'b0000, 4'b0100);
        step("rr3", 4'b1111, 4'b0000, 4'b1000);
        step("rr4", 4'b1111, 4'b0000, 4'b0001);

        // Lock on requester 1 released after MAXLOCK grants
        for (int i = 0; i < 4; i++) step("lk1", 4'b0110, 4'b0010, 4'b0010);
        step("lk_rel", 4'b0110, 4'b0010, 4'b0100);

        // Lock on 2, then drop req[2]: idle cycle, then wrap to requester 0
        step("lk2", 4'b0100, 4'b0100, 4'b0100);
        step("drop", 4'b0001, 4'b0000, 4'b0000);
        step("wrap0", 4'b0001, 4'b0000, 4'b0001);

        // Reset while locked on requester 3 holding A5
        tb_wd[3] = 8'hA5;
        step("lk3", 4'b1000, 4'b1000, 4'b1000);
        check("lk3_a5", 32'(q), 32'hA5);
        do_reset(4'b1000, 4'b1000);
        step("post_rst", 4'b1001, 4'b0000, 4'b0001);
        step("post_rst2", 4'b1001, 4'b0000, 4'b1000);

        // Single requester, data changing each cycle
        for (int i = 1; i <= 3; i++) begin
            tb_wd[2] = 8'(i);
            step("single", 4'b0100, 4'b0000, 4'b0100);
            check("single_data", 32'(q), 32'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
